hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
Pipeline hazard controller for the 5-stage RV32 core. It generates the execute-stage forwarding selects and the load-use stall. It also flushes the pipeline on taken branches and jumps. It sequences multi-cycle execute operations (mul/div) by holding F/D/E and inserting bubbles into M until the operation completes. It also keeps a saturating stall-cycle performance counter.

Parameters:
MULTI_LAT, 4, total cycles a multi-cycle op occupies E (legal range 2..16)
CNT_W, 4, width of the multi-cycle down-counter (must hold MULTI_LAT-2)

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-low reset
Rs1D  input  5  rs1 of instruction in D
Rs2D  input  5  rs2 of instruction in D
Rs1E  input  5  rs1 of instruction in E
Rs2E  input  5  rs2 of instruction in E
RdE  input  5  rd of instruction in E
RdM  input  5  rd of instruction in M
RdW  input  5  rd of instruction in W
RegWriteM  input  1  M-stage writes register file
RegWriteW  input  1  W-stage writes register file
ResultSrcE  input  2  result select of E instruction (2'b01 = load)
PCSrcE  input  1  taken branch/jump resolved in E
MultiE  input  1  instruction in E is multi-cycle
ForwardA_E  output  2  SrcA select: 00 RD1_E, 01 ResultW, 10 ALU_ResultM
ForwardB_E  output  2  SrcB select, same encoding
StallF  output  1  hold PC
StallD  output  1  hold IF/ID register
StallE  output  1  hold ID/EX register
FlushD  output  1  clear IF/ID register
FlushE  output  1  clear ID/EX register
FlushM  output  1  load bubble into EX/MEM register
MultiDoneE  output  1  multi-cycle result valid this cycle
Busy  output  1  multi-cycle FSM in BUSY
StallCount  output  32  saturating count of cycles with StallF=1

Behaviour:
- Forwarding (combinational, per operand X in {1,2}):
  - 10 if RegWriteM & RdM!=0 & RdM==RsXE.
  - Else 01 if RegWriteW & RdW!=0 & RdW==RsXE.
  - Else 00.
  - M has priority over W. x0 is never forwarded.
- lwStall = (ResultSrcE==01) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- FSM states: IDLE, BUSY. Down-counter cnt[CNT_W-1:0].
  - IDLE & MultiE & !PCSrcE: multiStall=1 this cycle. Next state BUSY, cnt<=MULTI_LAT-2.
  - BUSY & cnt!=0: multiStall=1, cnt<=cnt-1.
  - BUSY & cnt==0: MultiDoneE=1, multiStall=0. Next state IDLE; the op advances to M on this edge.
  - The op therefore occupies E for exactly MULTI_LAT cycles. MultiDoneE is high only in the last cycle.
  - Back-to-back multi ops: the IDLE cycle following DONE accepts the next MultiE with no gap.
- Output equations:
  - StallF = StallD = multiStall | (lwStall & !multiStall).
  - StallE = multiStall.
  - FlushM = multiStall.
  - FlushE = (lwStall & !multiStall) | PCSrcE.
  - FlushD = PCSrcE.
  - Busy = (state==BUSY).
- lwStall is masked during multiStall so that FlushE never kills a multi op being held in E.
- Simultaneous PCSrcE & MultiE in IDLE: MultiE is ignored (defensive; decoder never produces this).
- StallCount increments on every clock with StallF=1. It holds at 32'hFFFF_FFFF.
- Reset (rst=0, asynchronous, any time including mid-BUSY): state=IDLE, cnt=0, StallCount=0. Registered outputs clear immediately. Combinational outputs follow inputs with IDLE state.
- Latency: all stall/flush/forward outputs are combinational from inputs and state in the same cycle. Only the FSM, cnt and StallCount are registered.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - RESULTSRC_LOAD=2'b01.
  - mc_state_t enum: IDLE, BUSY.
- Sub-module forward_unit is combinational. It takes Rs, RdM, RdW, RegWriteM, RegWriteW and returns fwd_sel_t. It is instantiated twice (A and B).
- FSM, counter, stall/flush logic and StallCount live in hazard_controller.

Test Plan:
1. RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=0 -> ForwardA_E=10, ForwardB_E=00. Repeat with RdM=0 -> ForwardA_E=01.
2. Load in E (ResultSrcE=01, RdE=7), Rs2D=7 -> StallF=StallD=FlushE=1, StallE=0; StallCount advances by 1. With RdE=0 -> no stall.
3. MULTI_LAT=4, MultiE held high 4 cycles -> StallE/FlushM high cycles 1-3, MultiDoneE only in cycle 4, Busy cycles 2-4, StallCount +3.
4. Load-use condition present during multi op BUSY -> FlushE stays 0 until MultiDoneE. After release, lwStall takes effect the next cycle.
5. PCSrcE=1 with MultiE=1 in IDLE -> FlushD=FlushE=1, state stays IDLE, MultiDoneE=0.
6. Assert rst=0 mid-BUSY (cnt=1) -> state IDLE, Busy=0 and StallCount=0 asynchronously. After release with MultiE=0 -> no stall. Also force 32'hFFFF_FFFF plus a stall -> count holds.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_t;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-facing signal bundle of the hazard controller; the pipeline drives
// register ids and stage controls, the controller returns selects, stalls and flushes.
interface hazard_controller_if;

    logic [4:0]           Rs1D;
    logic [4:0]           Rs2D;
    logic [4:0]           Rs1E;
    logic [4:0]           Rs2E;
    logic [4:0]           RdE;
    logic [4:0]           RdM;
    logic [4:0]           RdW;
    logic                 RegWriteM;
    logic                 RegWriteW;
    logic [1:0]           ResultSrcE;
    logic                 PCSrcE;
    logic                 MultiE;

    hazard_pkg::fwd_sel_t ForwardA_E;
    hazard_pkg::fwd_sel_t ForwardB_E;
    logic                 StallF;
    logic                 StallD;
    logic                 StallE;
    logic                 FlushD;
    logic                 FlushE;
    logic                 FlushM;
    logic                 MultiDoneE;
    logic                 Busy;
    logic [31:0]          StallCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MultiE,
        input  ForwardA_E, ForwardB_E, StallF, StallD, StallE,
        input  FlushD, FlushE, FlushM, MultiDoneE, Busy, StallCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MultiE,
        output ForwardA_E, ForwardB_E, StallF, StallD, StallE,
        output FlushD, FlushE, FlushM, MultiDoneE, Busy, StallCount
    );

endinterface

// File: rtl/hazard_controller_forward_unit.sv
// Execute-stage operand forwarding select for one source register.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       reg_write_m_i,
    input  logic       reg_write_w_i,
    output fwd_sel_t   fwd_o
);

    // The younger M result wins over W; x0 is hardwired zero and never forwarded.
    always_comb begin
        fwd_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_i)) begin
            fwd_o = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_i)) begin
            fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage RV32 core: forwarding, load-use stall,
// branch flush, multi-cycle execute sequencing and a stall-cycle counter.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MULTI_LAT = 4,
    parameter int CNT_W     = 4
) (
    input  logic          clk,
    input  logic          rst,
    hazard_controller_if.slave hz
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI_LAT - 2);

    mc_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      stall_count_q;
    logic [31:0]      stall_count_d;

    logic lw_stall;
    logic multi_start;
    logic multi_stall;
    logic stall_f;

    forward_unit u_fwd_a (
        .rs_i          (hz.Rs1E),
        .rd_m_i        (hz.RdM),
        .rd_w_i        (hz.RdW),
        .reg_write_m_i (hz.RegWriteM),
        .reg_write_w_i (hz.RegWriteW),
        .fwd_o         (hz.ForwardA_E)
    );

    forward_unit u_fwd_b (
        .rs_i          (hz.Rs2E),
        .rd_m_i        (hz.RdM),
        .rd_w_i        (hz.RdW),
        .reg_write_m_i (hz.RegWriteM),
        .reg_write_w_i (hz.RegWriteW),
        .fwd_o         (hz.ForwardB_E)
    );

    // A taken branch in E squashes a multi op before it starts.
    always_comb begin
        lw_stall    = (hz.ResultSrcE == RESULTSRC_LOAD) && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
        multi_start = (state_q == IDLE) && hz.MultiE && !hz.PCSrcE;
        multi_stall = multi_start || ((state_q == BUSY) && (cnt_q != '0));
        stall_f     = multi_stall || (lw_stall && !multi_stall);
    end

    // lwStall is masked while a multi op is held so FlushE cannot kill it.
    assign hz.StallF     = stall_f;
    assign hz.StallD     = stall_f;
    assign hz.StallE     = multi_stall;
    assign hz.FlushM     = multi_stall;
    assign hz.FlushE     = (lw_stall && !multi_stall) || hz.PCSrcE;
    assign hz.FlushD     = hz.PCSrcE;
    assign hz.MultiDoneE = (state_q == BUSY) && (cnt_q == '0);
    assign hz.Busy       = (state_q == BUSY);
    assign hz.StallCount = stall_count_q;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_f && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            case (state_q)
                IDLE: begin
                    if (multi_start) begin
                        state_q <= BUSY;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller (MULTI_LAT=4): forwarding, load-use,
// multi-cycle sequencing, branch flush, async reset and counter saturation.
module tb_hazard_controller;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_controller_if hz();

  hazard_controller #(.MULTI_LAT(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  int passed = 0;
  int total  = 0;
  logic [11:0] exp_q[$];
  logic [31:0] exp_cnt;

  // {ForwardA, ForwardB, StallF, StallD, StallE, FlushD, FlushE, FlushM, MultiDoneE, Busy}
  function automatic logic [11:0] obs();
    return {hz.ForwardA_E, hz.ForwardB_E, hz.StallF, hz.StallD, hz.StallE,
            hz.FlushD, hz.FlushE, hz.FlushM, hz.MultiDoneE, hz.Busy};
  endfunction

  function automatic logic [11:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic sf, input logic se, input logic fd,
                                     input logic fe, input logic fm, input logic md,
                                     input logic bz);
    return {fa, fb, sf, sf, se, fd, fe, fm, md, bz};
  endfunction

  function automatic logic [1:0] fwd_model(input logic [4:0] rs, input logic [4:0] rdm,
                                           input logic [4:0] rdw, input logic rwm,
                                           input logic rww);
    if (rwm && rdm != 5'd0 && rdm == rs) return 2'b10;
    if (rww && rdw != 5'd0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic set_in(input logic [4:0] rs1d, input logic [4:0] rs2d,
                        input logic [4:0] rs1e, input logic [4:0] rs2e,
                        input logic [4:0] rde, input logic [4:0] rdm,
                        input logic [4:0] rdw, input logic rwm, input logic rww,
                        input logic [1:0] rsrc, input logic pcsrc, input logic multi);
    hz.Rs1D = rs1d; hz.Rs2D = rs2d; hz.Rs1E = rs1e; hz.Rs2E = rs2e;
    hz.RdE = rde; hz.RdM = rdm; hz.RdW = rdw;
    hz.RegWriteM = rwm; hz.RegWriteW = rww;
    hz.ResultSrcE = rsrc; hz.PCSrcE = pcsrc; hz.MultiE = multi;
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  // Advance one clock; the counter model counts the cycle if StallF was expected.
  task automatic clock_cycle(input logic [11:0] e);
    @(posedge clk);
    if (e[7] && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [11:0] x;
    rst = 1'b0;
    idle_in();
    exp_cnt = 32'd0;
    exp_q.push_back(ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    #1;
    x = exp_q.pop_front();
    total++;
    if (obs() !== x) $display("FAIL reset_outputs: got %b expected %b", obs(), x);
    else passed++;
    total++;
    if (hz.StallCount !== 32'd0) $display("FAIL reset_count: got %h expected 0", hz.StallCount);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_forwarding();
    logic [11:0] e, x;
    logic [4:0] r1, r2, rm, rw;
    logic wm, ww;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        r1 = 5; r2 = 0; rm = 5; rw = 5; wm = 1; ww = 1;
      end else if (i == 1) begin
        r1 = 5; r2 = 0; rm = 0; rw = 5; wm = 1; ww = 1;
      end else begin
        r1 = 5'($urandom_range(0, 3)); r2 = 5'($urandom_range(0, 3));
        rm = 5'($urandom_range(0, 3)); rw = 5'($urandom_range(0, 3));
        wm = 1'($urandom_range(0, 1)); ww = 1'($urandom_range(0, 1));
      end
      set_in(0, 0, r1, r2, 0, rm, rw, wm, ww, 2'b00, 1'b0, 1'b0);
      if (i == 0)      e = ev(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      else if (i == 1) e = ev(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      else e = ev(fwd_model(r1, rm, rw, wm, ww), fwd_model(r2, rm, rw, wm, ww),
                  0, 0, 0, 0, 0, 0, 0);
      exp_q.push_back(e);
      #1;
      x = exp_q.pop_front();
      total++;
      if (obs() !== x) $display("FAIL forward step %0d: got %b expected %b", i, obs(), x);
      else passed++;
      clock_cycle(e);
    end
    idle_in();
  endtask

  task automatic test_load_use();
    logic [11:0] e, x;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        set_in(0, 7, 0, 0, 7, 0, 0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        e = ev(2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0);
      end else begin
        set_in(0, 7, 0, 0, 0, 0, 0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        e = ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      end
      exp_q.push_back(e);
      #1;
      x = exp_q.pop_front();
      total++;
      if (obs() !== x) $display("FAIL load_use step %0d: got %b expected %b", i, obs(), x);
      else passed++;
      clock_cycle(e);
      total++;
      if (hz.StallCount !== exp_cnt)
        $display("FAIL load_use_count step %0d: got %0d expected %0d", i, hz.StallCount, exp_cnt);
      else passed++;
    end
    idle_in();
  endtask

  task automatic test_back_to_back_multi();
    logic [11:0] e, x;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) set_in(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
      else idle_in();
      if (i == 8)          e = ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      else if (i % 4 == 0) e = ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0);
      else if (i % 4 == 3) e = ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
      else                 e = ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 1);
      exp_q.push_back(e);
      #1;
      x = exp_q.pop_front();
      total++;
      if (obs() !== x) $display("FAIL multi cycle %0d: got %b expected %b", i + 1, obs(), x);
      else passed++;
      clock_cycle(e);
    end
    total++;
    if (hz.StallCount !== exp_cnt)
      $display("FAIL multi_count: got %0d expected %0d", hz.StallCount, exp_cnt);
    else passed++;
  endtask

  task automatic test_multi_masks_load_use();
    logic [11:0] e, x;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin
          set_in(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
          e = ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0);
        end
        1, 2: begin
          set_in(7, 0, 0, 0, 7, 0, 0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
          e = ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 1);
        end
        3: begin
          set_in(7, 0, 0, 0, 7, 0, 0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
          e = ev(2'b00, 2'b00, 1, 0, 0, 1, 0, 1, 1);
        end
        default: begin
          set_in(7, 0, 0, 0, 7, 0, 0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
          e = ev(2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0);
        end
      endcase
      exp_q.push_back(e);
      #1;
      x = exp_q.pop_front();
      total++;
      if (obs() !== x) $display("FAIL multi_lw cycle %0d: got %b expected %b", i + 1, obs(), x);
      else passed++;
      clock_cycle(e);
    end
    idle_in();
    total++;
    if (hz.StallCount !== exp_cnt)
      $display("FAIL multi_lw_count: got %0d expected %0d", hz.StallCount, exp_cnt);
    else passed++;
  endtask

  task automatic test_branch_flush();
    logic [11:0] e, x;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        set_in(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        e = ev(2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0);
      end else begin
        idle_in();
        e = ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      end
      exp_q.push_back(e);
      #1;
      x = exp_q.pop_front();
      total++;
      if (obs() !== x) $display("FAIL branch_flush step %0d: got %b expected %b", i, obs(), x);
      else passed++;
      clock_cycle(e);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [11:0] e, x;
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
      e = (i == 0) ? ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0)
                   : ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 1);
      exp_q.push_back(e);
      #1;
      x = exp_q.pop_front();
      total++;
      if (obs() !== x) $display("FAIL mid_busy cycle %0d: got %b expected %b", i + 1, obs(), x);
      else passed++;
      if (i < 2) clock_cycle(e);
    end
    // Now BUSY with one hold cycle left; reset lands between clock edges.
    #1;
    idle_in();
    rst = 1'b0;
    exp_cnt = 32'd0;
    exp_q.push_back(ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    #1;
    x = exp_q.pop_front();
    total++;
    if (obs() !== x) $display("FAIL async_reset_outputs: got %b expected %b", obs(), x);
    else passed++;
    total++;
    if (hz.StallCount !== 32'd0) $display("FAIL async_reset_count: got %h expected 0", hz.StallCount);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    e = ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(e);
    #1;
    x = exp_q.pop_front();
    total++;
    if (obs() !== x) $display("FAIL post_reset_idle: got %b expected %b", obs(), x);
    else passed++;
    clock_cycle(e);
    total++;
    if (hz.StallCount !== exp_cnt)
      $display("FAIL post_reset_count: got %0d expected %0d", hz.StallCount, exp_cnt);
    else passed++;
  endtask

  task automatic test_saturation();
    logic [11:0] e;
    force dut.stall_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_count_q;
    exp_cnt = 32'hFFFF_FFFF;
    set_in(7, 0, 0, 0, 7, 0, 0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
    e = ev(2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0);
    clock_cycle(e);
    total++;
    if (hz.StallCount !== exp_cnt)
      $display("FAIL saturate_count: got %h expected %h", hz.StallCount, exp_cnt);
    else passed++;
    idle_in();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_back_to_back_multi();
    test_multi_masks_load_use();
    test_branch_flush();
    test_reset_mid_busy();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
